// File: rtl/reg_file_pkg.sv
// core_pkg: shared constants and types for the RV32 core register file.
package core_pkg;
    localparam int XLEN = 32;
    localparam int REG_AW = 5;
    localparam int REG_ZERO = 0;
    localparam int REG_RA = 1;
    localparam int REG_SP = 2;
    typedef enum logic {RF_INIT, RF_READY} rf_state_t;
endpackage

// File: rtl/reg_file_read_port.sv
// rf_read_port: combinational read mux with x0 mask, init mask and optional write bypass.
module rf_read_port
    import core_pkg::*;
#(
    parameter int XLEN = core_pkg::XLEN,
    parameter int AW = core_pkg::REG_AW,
    parameter bit BYPASS = 1'b1
) (
    input  logic [AW-1:0]   addr,
    input  logic            busy,
    input  logic            we,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [XLEN-1:0] stored,
    output logic [XLEN-1:0] data
);
    // addr != 0 already implies wr_addr != 0 on a bypass hit
    always_comb data = (busy || addr == AW'(REG_ZERO)) ? '0 :
                       (BYPASS && we && wr_addr == addr) ? wr_data : stored;
endmodule

// File: rtl/reg_file.sv
// reg_file: 2R1W integer register file with post-reset sequential initialisation.
module reg_file
    import core_pkg::*;
#(
    parameter int XLEN = core_pkg::XLEN,
    parameter int NREG = 32,
    parameter int AW = core_pkg::REG_AW,
    parameter logic [XLEN-1:0] SP_INIT = 32'h0000_3FFC,
    parameter bit BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic            init_busy
);
    localparam logic [AW:0] IDX_LAST = (AW+1)'(NREG - 1);
    localparam logic [AW:0] IDX_SP = (AW+1)'(REG_SP);
    rf_state_t state, state_nx;
    logic [AW:0] idx;
    logic [XLEN-1:0] regs [NREG];
    logic wr_en;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RF_INIT;
            idx <= '0;
        end else begin
            state <= state_nx;
            idx <= (state == RF_INIT) ? idx + 1'b1 : idx;
        end
    end
    always_comb begin
        state_nx = state;
        if (state == RF_INIT && idx == IDX_LAST) state_nx = RF_READY;
    end
    assign init_busy = (state == RF_INIT);
    assign wr_en = we && state == RF_READY;
    // no reset on the array so it can map to distributed RAM
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == RF_INIT) regs[idx[AW-1:0]] <= (idx == IDX_SP) ? SP_INIT : '0;
            else if (wr_en && rd_addr != AW'(REG_ZERO)) regs[rd_addr] <= rd_data;
        end
    end
    rf_read_port #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rs1 (
        .addr(rs1_addr), .busy(init_busy), .we(wr_en), .wr_addr(rd_addr),
        .wr_data(rd_data), .stored(regs[rs1_addr]), .data(rs1_data)
    );
    rf_read_port #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rs2 (
        .addr(rs2_addr), .busy(init_busy), .we(wr_en), .wr_addr(rd_addr),
        .wr_data(rd_data), .stored(regs[rs2_addr]), .data(rs2_data)
    );
    rf_read_port #(.XLEN(XLEN), .AW(AW), .BYPASS(1'b0)) u_dbg (
        .addr(dbg_addr), .busy(init_busy), .we(wr_en), .wr_addr(rd_addr),
        .wr_data(rd_data), .stored(regs[dbg_addr]), .data(dbg_data)
    );
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Integer register file for the single-cycle RV32 core. It sits directly upstream of the ALU.
- Two combinational read ports drive the ALU A/B operand muxes; one synchronous write port takes the write-back result.
- After reset, an internal sequencer initialises the storage one entry per cycle, so the array maps to distributed RAM. The core is held off by `init_busy` until initialisation is complete.

Parameters:
- XLEN, 32, data width of each register and of every data port.
- NREG, 32, number of architectural registers (power of two, >= 4).
- AW, 5, address width; must equal log2(NREG).
- SP_INIT, 32'h0000_3FFC, value loaded into x2 (sp) during initialisation.
- BYPASS, 1, 1 = a read of the address being written in the same cycle returns the write data; 0 = it returns the stored value.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_data  out  XLEN  read port 1 data (to ALU A mux).
- rs2_data  out  XLEN  read port 2 data (to ALU B mux).
- we  in  1  write enable.
- rd_addr  in  AW  write address.
- rd_data  in  XLEN  write data (ALU Result / load data / PC+4).
- dbg_addr  in  AW  debug read address (bench/trace).
- dbg_data  out  XLEN  debug read data; no bypass on this port.
- init_busy  out  1  high while the initialisation sequence runs.

Behaviour:
- One clock domain, `clk`. Reset is synchronous and active-high on `rst`; nothing is sampled asynchronously.
- FSM states: INIT, READY.
  - While `rst`=1 at an edge: state <= INIT, idx <= 0.
  - INIT: each edge writes entry[idx]. The written value is SP_INIT when idx==2, otherwise 0. Then idx <= idx+1.
  - INIT -> READY on the edge that writes idx==NREG-1.
  - INIT therefore lasts exactly NREG cycles after `rst` falls.
  - READY: stays in READY until `rst`.
- `init_busy` = (state==INIT). It is 1 during reset and for NREG cycles after `rst` deasserts, then 0.
- Read ports (all of rs1, rs2, dbg) are combinational from address and storage; there is no read latency.
  - While `init_busy`=1, all read ports return 0 regardless of address or storage contents.
- Writes occur only in READY, with `we`=1 and rd_addr != 0, at the rising edge. Any `we` during INIT or reset is dropped silently, with no deferred write.
- x0 is hardwired:
  - Any read of address 0 returns 0 on every port, even when BYPASS=1 and a write to 0 is presented.
  - Writes to address 0 never change storage.
- Bypass (BYPASS=1, READY): if `we`=1, rd_addr != 0 and rsN_addr==rd_addr, then rsN_data = rd_data in the same cycle. rs1 and rs2 are bypassed independently; both may hit the same address.
- BYPASS=0: the write becomes visible on the cycle after the edge.
- `rst` asserted in the middle of INIT or READY:
  - Sequencing restarts from idx 0.
  - Registers already written keep stale contents until re-initialised. This is invisible, because reads are masked during INIT.
- Reset values of outputs:
  - init_busy = 1.
  - rs1_data, rs2_data, dbg_data = 0.
- Widths: idx is AW+1 bits so the terminal compare cannot wrap early. rd_data is stored unmodified, with no sign handling.

Decomposition:
- Shared package `core_pkg` holds:
  - XLEN and REG_AW constants.
  - Register index constants REG_ZERO=0, REG_RA=1, REG_SP=2.
  - The FSM enum typedef `rf_state_t` {RF_INIT, RF_READY}.
- One sub-module is natural: `rf_read_port`. It is combinational and holds the address-0 mask, the init mask and the bypass compare. It is instantiated three times, with bypass tied off for the debug port.
- The storage array and FSM stay in `reg_file`.

Test Plan:
- Reset then init: hold `rst` 3 cycles and release, with reads of x2 and x5 during INIT. Required: init_busy=1 for exactly 32 cycles after release; reads = 0 during INIT; afterwards x2 = 32'h0000_3FFC and x5 = 0.
- Basic write/read: write x5 = 32'hDEAD_BEEF, then on the next cycle read rs1=x5, rs2=x5. Required: both = 32'hDEAD_BEEF. Read rs1=x6 → 0.
- x0 protection: we=1, rd=0, data 32'hFFFF_FFFF with rs1=0 in the same cycle. Required: rs1_data=0 that cycle and every later cycle.
- Same-cycle bypass with BYPASS=1: x7 holds 1; write x7 = 32'h1234_5678 with rs1=7, rs2=7. Required: both ports = 32'h1234_5678 in the write cycle and dbg(7) = 1 until the edge. With BYPASS=0: both read 1 in the write cycle and 32'h1234_5678 afterwards.
- Writes during INIT dropped: release `rst`, then at cycle 5 write x9 = 32'hAAAA_AAAA. Required: after init, x9 = 0.
- Mid-operation reset: write x3 = 5 in READY, assert `rst` for 1 cycle and wait for init. Required: init_busy high for 32 cycles again, x3 = 0, x2 = SP_INIT.
